// File: rtl/yari_mem_arbiter.sv
// Purpose : merges the yari I-fetch (read-only) and D-mem (read/write) request
//           streams onto one pipelined slave port and steers read data back
//           through an in-order 1-bit source-tag FIFO.
// Latency : request and read-data paths are combinational (zero added cycles).
// Backpr. : per-side wait = not granted or slave m_wait; a stalled grant is locked
//           until accepted; reads are blocked while DEPTH reads are in flight.
//
// Ports:
//   clock, rst                 clock and synchronous active-high reset
//   i_a/i_rd/i_wait            I-side request; i_rdata/i_rdv I-side response
//   d_a/d_rd/d_wr/d_wd/d_be    D-side request; d_wait stall; d_rdata/d_rdv response
//   m_a/m_rd/m_wr/m_wd/m_be    slave request; m_wait stall; m_rdata/m_rdv response
//   outstanding                reads in flight
//   err                        sticky: response arrived with no read outstanding
module yari_mem_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic                     clock,
  input  logic                     rst,
  // I side
  input  logic [AW-1:0]            i_a,
  input  logic                     i_rd,
  output logic                     i_wait,
  output logic [31:0]              i_rdata,
  output logic                     i_rdv,
  // D side
  input  logic [AW-1:0]            d_a,
  input  logic                     d_rd,
  input  logic                     d_wr,
  input  logic [31:0]              d_wd,
  input  logic [3:0]               d_be,
  output logic                     d_wait,
  output logic [31:0]              d_rdata,
  output logic                     d_rdv,
  // slave port
  output logic [AW-1:0]            m_a,
  output logic                     m_rd,
  output logic                     m_wr,
  output logic [31:0]              m_wd,
  output logic [3:0]               m_be,
  input  logic                     m_wait,
  input  logic [31:0]              m_rdata,
  input  logic                     m_rdv,
  // status
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_I    = 2'd1,
    LOCK_D    = 2'd2
  } lock_e;

  // Tag FIFO: bit value 0 = I-side read, 1 = D-side read.
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  lock_e            lock_q, lock_d;
  logic             last_grant_q, last_grant_d;  // 0 = I, 1 = D
  logic             err_q, err_d;

  logic full, empty;
  logic i_elig, d_elig;
  logic gnt_i, gnt_d;
  logic req_any, accept, push, pop, head_tag;

  always_comb begin
    full   = (count_q == CW'(DEPTH));
    empty  = (count_q == '0);
    // Full blocks new reads even when a pop lands in the same cycle, which keeps
    // the eligibility decision off the m_rdv path.
    i_elig = i_rd & ~full;
    d_elig = d_wr | (d_rd & ~full);

    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!rst) begin
      case (lock_q)
        LOCK_I:  gnt_i = 1'b1;
        LOCK_D:  gnt_d = 1'b1;
        default: begin
          if (i_elig && d_elig) begin
            // Tie goes to the side that did not win the last acceptance.
            if (last_grant_q) gnt_i = 1'b1;
            else              gnt_d = 1'b1;
          end else if (i_elig) begin
            gnt_i = 1'b1;
          end else if (d_elig) begin
            gnt_d = 1'b1;
          end
        end
      endcase
    end

    m_a  = gnt_i ? i_a : d_a;
    m_wd = d_wd;
    m_be = gnt_i ? 4'hF : d_be;
    // A locked side that dropped its request issues nothing; the lock then lapses.
    m_rd = (gnt_i & i_rd) | (gnt_d & d_rd);
    m_wr = gnt_d & d_wr;

    i_wait = ~gnt_i | m_wait;
    d_wait = ~gnt_d | m_wait;

    req_any  = m_rd | m_wr;
    accept   = req_any & ~m_wait;
    push     = accept & m_rd;
    pop      = ~rst & m_rdv & ~empty;
    head_tag = fifo_q[head_q];

    i_rdata = m_rdata;
    d_rdata = m_rdata;
    i_rdv   = pop & ~head_tag;
    d_rdv   = pop &  head_tag;

    fifo_d = fifo_q;
    if (push) fifo_d[tail_q] = gnt_d;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    head_d  = pop  ? head_q + PW'(1) : head_q;
    count_d = count_q + CW'(push) - CW'(pop);

    if (accept)       lock_d = LOCK_NONE;
    else if (req_any) lock_d = gnt_d ? LOCK_D : LOCK_I;
    else              lock_d = LOCK_NONE;

    last_grant_d = accept ? gnt_d : last_grant_q;
    err_d        = err_q | (~rst & m_rdv & empty);

    outstanding = count_q;
    err         = err_q;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      fifo_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      lock_q       <= LOCK_NONE;
      last_grant_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      lock_q       <= lock_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule
